vm_page_table: RTL and testbench

//  Single-level page table for the 12-bit-VA / 10-bit-PA virtual-memory subsystem.

---
 rtl/vm_pkg.sv | 27 ++
 rtl/vm_page_table.sv | 50 +++++
 tb/tb_vm_page_table.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared address-space widths and page table entry type
package vm_pkg;

  localparam int VA_W     = 12;
  localparam int PA_W     = 10;
  localparam int OFFSET_W = 4;
  localparam int VPN_W    = VA_W - OFFSET_W;
  localparam int PPN_W    = PA_W - OFFSET_W;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [PPN_W-1:0] ppn;
  } pte_t;

  // Identity map covers only the pages that exist physically; the rest start invalid.
  function automatic pte_t reset_pte(input int unsigned idx, input bit identity_map);
    pte_t e;
    e = '0;
    if (identity_map && (idx < (32'd1 << PPN_W))) begin
      e.valid = 1'b1;
      e.ppn   = PPN_W'(idx);
    end
    return e;
  endfunction

endpackage

// File: rtl/vm_page_table.sv
// rtl/vm_page_table.sv - single-level VPN->PPN table, async lookup, sync install/dirty-mark
module vm_page_table #(
  parameter int VPN_W   = vm_pkg::VPN_W,
  parameter int PPN_W   = vm_pkg::PPN_W,
  parameter bit RST_MAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VPN_W-1:0] vpn,
  output logic [PPN_W-1:0] ppn,
  output logic             valid,
  output logic             dirty,
  input  logic             wr_en,
  input  logic [VPN_W-1:0] wr_vpn,
  input  logic [PPN_W-1:0] wr_ppn,
  input  logic             wr_valid,
  input  logic             mark_dirty,
  input  logic [VPN_W-1:0] dirty_vpn
);

  import vm_pkg::*;

  localparam int DEPTH = 1 << VPN_W;

  pte_t table_q [DEPTH];
  pte_t lookup;

  // No bypass: a same-cycle read sees the entry as it was before this edge.
  assign lookup = table_q[vpn];
  assign ppn    = lookup.ppn;
  assign valid  = lookup.valid;
  assign dirty  = lookup.dirty;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= reset_pte(i, RST_MAP);
      end
    end else begin
      if (mark_dirty && table_q[dirty_vpn].valid) begin
        table_q[dirty_vpn].dirty <= 1'b1;
      end
      // Issued last so an install to the same index overrides the dirty mark.
      if (wr_en) begin
        table_q[wr_vpn] <= '{valid: wr_valid, dirty: 1'b0, ppn: wr_ppn};
      end
    end
  end

endmodule

// File: tb/tb_vm_page_table.sv
// tb/tb_vm_page_table.sv - scoreboard bench for vm_page_table
module tb_vm_page_table;

  logic       clk;
  logic       rst;
  logic [7:0] vpn;
  logic [5:0] ppn;
  logic       valid;
  logic       dirty;
  logic       wr_en;
  logic [7:0] wr_vpn;
  logic [5:0] wr_ppn;
  logic       wr_valid;
  logic       mark_dirty;
  logic [7:0] dirty_vpn;

  typedef struct {
    string      name;
    logic [5:0] ppn;
    logic       valid;
    logic       dirty;
  } exp_t;

  exp_t exp_q [$];
  int   n_compared;
  int   n_failed;

  vm_page_table #(.VPN_W(8), .PPN_W(6), .RST_MAP(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .vpn       (vpn),
    .ppn       (ppn),
    .valid     (valid),
    .dirty     (dirty),
    .wr_en     (wr_en),
    .wr_vpn    (wr_vpn),
    .wr_ppn    (wr_ppn),
    .wr_valid  (wr_valid),
    .mark_dirty(mark_dirty),
    .dirty_vpn (dirty_vpn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expectation per cycle, compared mid-cycle against the live outputs.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_compared++;
      if ({ppn, valid, dirty} !== {e.ppn, e.valid, e.dirty}) begin
        n_failed++;
        $display("FAIL %s vpn=%02h got ppn=%02h valid=%b dirty=%b want ppn=%02h valid=%b dirty=%b",
                 e.name, vpn, ppn, valid, dirty, e.ppn, e.valid, e.dirty);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    rst        = 1'b0;
    wr_en      = 1'b0;
    mark_dirty = 1'b0;
  endtask

  task automatic expect_now(input logic [7:0] v, input string nm,
                            input logic [5:0] ep, input logic ev, input logic ed);
    exp_t e;
    vpn     = v;
    e.name  = nm;
    e.ppn   = ep;
    e.valid = ev;
    e.dirty = ed;
    exp_q.push_back(e);
  endtask

  initial begin
    n_compared = 0;
    n_failed   = 0;
    rst        = 1'b1;
    vpn        = 8'h00;
    wr_en      = 1'b0;
    wr_vpn     = 8'h00;
    wr_ppn     = 6'h00;
    wr_valid   = 1'b0;
    mark_dirty = 1'b0;
    dirty_vpn  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset identity map boundaries
    expect_now(8'h00, "rst_vpn00", 6'h00, 1'b1, 1'b0);
    next_cycle(); expect_now(8'h3F, "rst_vpn3f", 6'h3F, 1'b1, 1'b0);
    next_cycle(); expect_now(8'h40, "rst_vpn40", 6'h00, 1'b0, 1'b0);

    // install: old contents during the write cycle, new after the edge
    next_cycle();
    wr_en = 1'b1; wr_vpn = 8'h80; wr_ppn = 6'h15; wr_valid = 1'b1;
    expect_now(8'h80, "wr_same_cycle_old", 6'h00, 1'b0, 1'b0);
    next_cycle(); expect_now(8'h80, "wr_installed", 6'h15, 1'b1, 1'b0);

    // dirty mark on valid and on invalid entries
    next_cycle();
    mark_dirty = 1'b1; dirty_vpn = 8'h05;
    expect_now(8'h05, "dirty_pre", 6'h05, 1'b1, 1'b0);
    next_cycle(); expect_now(8'h05, "dirty_set", 6'h05, 1'b1, 1'b1);
    next_cycle();
    mark_dirty = 1'b1; dirty_vpn = 8'h90;
    expect_now(8'h90, "dirty_inv_pre", 6'h00, 1'b0, 1'b0);
    next_cycle(); expect_now(8'h90, "dirty_inv_ignored", 6'h00, 1'b0, 1'b0);

    // install and mark on the same index: install wins
    next_cycle();
    wr_en = 1'b1; wr_vpn = 8'h05; wr_ppn = 6'h2A; wr_valid = 1'b1;
    mark_dirty = 1'b1; dirty_vpn = 8'h05;
    expect_now(8'h05, "collide_old", 6'h05, 1'b1, 1'b1);
    next_cycle(); expect_now(8'h05, "collide_install_wins", 6'h2A, 1'b1, 1'b0);

    // install and mark on different indices: both land
    next_cycle();
    wr_en = 1'b1; wr_vpn = 8'h10; wr_ppn = 6'h01; wr_valid = 1'b1;
    mark_dirty = 1'b1; dirty_vpn = 8'h06;
    expect_now(8'h06, "split_pre", 6'h06, 1'b1, 1'b0);
    next_cycle(); expect_now(8'h06, "split_dirty", 6'h06, 1'b1, 1'b1);
    next_cycle(); expect_now(8'h10, "split_install", 6'h01, 1'b1, 1'b0);

    // reset beats a concurrent install and clears dirty bits
    next_cycle();
    mark_dirty = 1'b1; dirty_vpn = 8'h07;
    expect_now(8'h80, "pre_rst_80", 6'h15, 1'b1, 1'b0);
    next_cycle();
    rst = 1'b1;
    wr_en = 1'b1; wr_vpn = 8'h80; wr_ppn = 6'h33; wr_valid = 1'b1;
    expect_now(8'h07, "pre_rst_07_dirty", 6'h07, 1'b1, 1'b1);
    next_cycle(); expect_now(8'h80, "rst_wins_80", 6'h00, 1'b0, 1'b0);
    next_cycle(); expect_now(8'h07, "rst_clr_07", 6'h07, 1'b1, 1'b0);
    next_cycle(); expect_now(8'h06, "rst_clr_06", 6'h06, 1'b1, 1'b0);
    next_cycle(); expect_now(8'h05, "rst_restore_05", 6'h05, 1'b1, 1'b0);
    next_cycle(); expect_now(8'h10, "rst_restore_10", 6'h10, 1'b1, 1'b0);

    // full sweep: each vpn checked in the cycle it is presented
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'(i);
      next_cycle();
      if (i < 64) expect_now(v, "sweep", v[5:0], 1'b1, 1'b0);
      else        expect_now(v, "sweep", 6'h00, 1'b0, 1'b0);
    end

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_failed++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
